// File: rtl/serial_word_receiver.sv
// Framed serial receiver (start=1, WIDTH bits MSB first, stop=0) with a one-word valid/ready output.
// outValid rises 1 clk after a good stop sample; a completed word is dropped (overrun) while outValid & !outReady.
module serial_word_receiver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             serialInput,
  input  logic             bitEnable,
  output logic [WIDTH-1:0] parallelOutput,
  output logic             outValid,
  input  logic             outReady,
  output logic             busy,
  output logic             frameError,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               vld_q, vld_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    vld_d   = vld_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;

    // A transfer empties the output unless a new word is loaded below.
    if (vld_q && outReady) begin
      vld_d = 1'b0;
    end

    if (bitEnable) begin
      unique case (state_q)
        IDLE: begin
          if (serialInput) begin
            state_d = DATA;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        DATA: begin
          shift_d = {shift_q[WIDTH-2:0], serialInput};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = STOP;
          end
        end
        STOP: begin
          state_d = IDLE;
          if (!serialInput) begin
            if (!vld_q || outReady) begin
              data_d = shift_q;
              vld_d  = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign parallelOutput = data_q;
  assign outValid       = vld_q;
  assign busy           = (state_q != IDLE);
  assign frameError     = ferr_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: frame-level queue model checked every cycle, plus directed literal checks.
module tb_serial_word_receiver;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr, serialInput, bitEnable, outReady;
  logic [W-1:0] parallelOutput;
  logic         outValid, busy, frameError, overrun;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;
  int gap    = 1;

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk            (clk),
    .clr            (clr),
    .serialInput    (serialInput),
    .bitEnable      (bitEnable),
    .parallelOutput (parallelOutput),
    .outValid       (outValid),
    .outReady       (outReady),
    .busy           (busy),
    .frameError     (frameError),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: collect sampled bits of the current frame, decode the word once the whole frame is in.
  bit           frm[$];
  logic [W-1:0] m_data = '0;
  bit           m_vld = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_busy = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] w;
    bit take;
    m_ferr = 1'b0;
    if (clr) begin
      frm.delete();
      m_data = '0;
      m_vld  = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      take = m_vld && outReady;
      if (take) m_vld = 1'b0;
      if (bitEnable && (frm.size() != 0 || serialInput)) frm.push_back(serialInput);
      if (frm.size() == W + 2) begin
        if (frm[W+1] == 1'b0) begin
          w = '0;
          for (int i = 1; i <= W; i++) w = (w << 1) | W'(frm[i]);
          if (!m_vld && (take || !m_vld)) begin
            m_data = w;
            m_vld  = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end else begin
          m_ferr = 1'b1;
        end
        frm.delete();
      end
    end
    m_busy = (frm.size() != 0);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_data",  parallelOutput, m_data);
      chk("model_valid", outValid,       m_vld);
      chk("model_busy",  busy,           m_busy);
      chk("model_ferr",  frameError,     m_ferr);
      chk("model_ovr",   overrun,        m_ovr);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic b);
    serialInput = b;
    bitEnable   = 1'b1;
    cyc();
  endtask

  task automatic stall();
    for (int k = 1; k < gap; k++) begin
      bitEnable   = 1'b0;
      serialInput = 1'($urandom);
      cyc();
    end
    bitEnable = 1'b1;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic stopb, input bit rdy_stop);
    strobe(1'b1);
    stall();
    if (gap > 1) chk("busy_stall", busy, 1);
    for (int i = W - 1; i >= 0; i--) begin
      strobe(w[i]);
      stall();
    end
    if (rdy_stop) outReady = 1'b1;
    strobe(stopb);
    if (rdy_stop) outReady = 1'b0;
    serialInput = 1'b0;
  endtask

  task automatic idle(input int n);
    serialInput = 1'b0;
    bitEnable   = 1'b1;
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    clr = 1'b1; serialInput = 1'b0; bitEnable = 1'b0; outReady = 1'b0;
    // 1. reset and idle line
    cyc();
    cmp_en = 1'b1;
    cyc();
    clr = 1'b0;
    chk("rst_data", parallelOutput, 8'h00);
    chk("rst_valid", outValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frameError, 0);
    chk("rst_ovr", overrun, 0);
    idle(20);
    chk("idle_busy", busy, 0);
    chk("idle_valid", outValid, 0);

    // 2. single frame, held until read
    send_frame(8'hA5, 1'b0, 1'b0);
    chk("f1_data", parallelOutput, 8'hA5);
    chk("f1_valid", outValid, 1);
    chk("f1_busy", busy, 0);
    idle(3);
    chk("f1_hold", parallelOutput, 8'hA5);
    chk("f1_hold_v", outValid, 1);
    outReady = 1'b1; cyc(); outReady = 1'b0;
    chk("f1_taken", outValid, 0);

    // 3. strobe every 4th cycle
    gap = 4;
    send_frame(8'hA5, 1'b0, 1'b0);
    chk("stall_data", parallelOutput, 8'hA5);
    chk("stall_valid", outValid, 1);
    chk("stall_busy_end", busy, 0);
    gap = 1;
    outReady = 1'b1; cyc(); outReady = 1'b0;

    // 4. framing error, then a good frame
    send_frame(8'h3C, 1'b1, 1'b0);
    chk("ferr_pulse", frameError, 1);
    chk("ferr_valid", outValid, 0);
    cyc();
    chk("ferr_gone", frameError, 0);
    send_frame(8'h0F, 1'b0, 1'b0);
    chk("after_ferr", parallelOutput, 8'h0F);
    chk("after_ferr_v", outValid, 1);
    outReady = 1'b1; cyc(); outReady = 1'b0;

    // 5. overrun, then consume-and-load on the stop cycle
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    chk("ovr_flag", overrun, 1);
    chk("ovr_keep", parallelOutput, 8'h11);
    idle(2);
    chk("ovr_sticky", overrun, 1);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    send_frame(8'h33, 1'b0, 1'b0);
    chk("f33", parallelOutput, 8'h33);
    send_frame(8'h44, 1'b0, 1'b1);
    chk("simul_data", parallelOutput, 8'h44);
    chk("simul_valid", outValid, 1);
    chk("simul_ovr", overrun, 0);

    // 6. reset mid-frame
    strobe(1'b1);
    strobe(1'b1); strobe(1'b1); strobe(1'b0); strobe(1'b0);
    chk("mid_busy", busy, 1);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("mid_data", parallelOutput, 8'h00);
    chk("mid_valid", outValid, 0);
    chk("mid_busy0", busy, 0);
    chk("mid_ovr", overrun, 0);
    send_frame(8'hC3, 1'b0, 1'b0);
    chk("fC3", parallelOutput, 8'hC3);
    chk("fC3_v", outValid, 1);
    idle(3);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
